// File: rtl/fetcher.sv
// Instruction fetch stage: icache lookup, miss refill handshake, one-instruction-per-cycle issue.
// Optional static jump prediction (JAL / C.J) when FETCHER_PREDICT_EN is defined.
module fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        stall,
  input  logic [31:0] rob_new_pc,
  output logic        fet_icache_enable,
  output logic [31:0] fet_pc,
  input  logic        icache_ready,
  input  logic [31:0] icache_inst,
  output logic        fet_mem_req,
  output logic [31:0] fet_mem_addr,
  input  logic        mem_busy,
  input  logic        mem_inst_ready,
  input  logic [31:0] mem_inst_addr,
  input  logic        dec_full,
  output logic        fet_inst_valid,
  output logic [31:0] fet_inst,
  output logic [31:0] fet_inst_pc,
  output logic        fet_is_c,
  output logic        fet_pred_jump
);

  typedef enum logic [0:0] {StRun, StMiss} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        pred_q;
  logic        is_c;
  logic [31:0] next_pc;
  logic        pred_hit;

  // The controller queues the request itself; busy never withdraws it.
  logic unused_mem_busy;
  assign unused_mem_busy = mem_busy;

  assign fet_icache_enable = (state_q == StRun) && !dec_full && !flush;
  assign fet_pc            = pc_q;
  assign fet_pred_jump     = pred_q;
  assign is_c              = (icache_inst[1:0] != 2'b11);

`ifdef FETCHER_PREDICT_EN
  logic        is_jal;
  logic        is_cj;
  logic [31:0] jal_imm;
  logic [31:0] cj_imm;

  assign is_jal  = (icache_inst[6:0] == 7'b1101111);
  assign is_cj   = (icache_inst[1:0] == 2'b01) && (icache_inst[15:13] == 3'b101);
  assign jal_imm = {{12{icache_inst[31]}}, icache_inst[19:12], icache_inst[20],
                    icache_inst[30:21], 1'b0};
  assign cj_imm  = {{20{icache_inst[12]}}, icache_inst[12], icache_inst[8], icache_inst[10:9],
                    icache_inst[6], icache_inst[7], icache_inst[2], icache_inst[11],
                    icache_inst[5:3], 1'b0};

  always_comb begin
    pred_hit = is_jal || is_cj;
    if (is_jal) begin
      next_pc = pc_q + jal_imm;
    end else if (is_cj) begin
      next_pc = pc_q + cj_imm;
    end else begin
      next_pc = pc_q + (is_c ? 32'd2 : 32'd4);
    end
  end
`else
  assign pred_hit = 1'b0;
  assign next_pc  = pc_q + (is_c ? 32'd2 : 32'd4);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StRun;
      pc_q           <= {RESET_PC[31:1], 1'b0};
      pred_q         <= 1'b0;
      fet_inst_valid <= 1'b0;
      fet_inst       <= 32'h0;
      fet_inst_pc    <= 32'h0;
      fet_is_c       <= 1'b0;
      fet_mem_req    <= 1'b0;
      fet_mem_addr   <= 32'h0;
    end else if (rdy) begin
      if (flush) begin
        state_q        <= StRun;
        pc_q           <= {rob_new_pc[31:1], 1'b0};
        pred_q         <= 1'b0;
        fet_inst_valid <= 1'b0;
        fet_mem_req    <= 1'b0;
      end else if (!stall) begin
        unique case (state_q)
          StRun: begin
            if (dec_full) begin
              fet_inst_valid <= 1'b0;
              pred_q         <= 1'b0;
            end else if (icache_ready) begin
              fet_inst_valid <= 1'b1;
              fet_inst       <= icache_inst;
              fet_inst_pc    <= pc_q;
              fet_is_c       <= is_c;
              pred_q         <= pred_hit;
              pc_q           <= {next_pc[31:1], 1'b0};
            end else begin
              fet_inst_valid <= 1'b0;
              pred_q         <= 1'b0;
              fet_mem_req    <= 1'b1;
              fet_mem_addr   <= pc_q;
              state_q        <= StMiss;
            end
          end
          StMiss: begin
            fet_inst_valid <= 1'b0;
            pred_q         <= 1'b0;
            // Responses for any other address belong to an abandoned request.
            if (mem_inst_ready && (mem_inst_addr == pc_q)) begin
              fet_mem_req <= 1'b0;
              state_q     <= StRun;
            end
          end
          default: state_q <= StRun;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// Scoreboard bench for fetcher: stimulus pushes expected issues, a negedge monitor pops and compares.
module tb_fetcher;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, stall, dec_full;
  logic [31:0] rob_new_pc;
  logic        fet_icache_enable;
  logic [31:0] fet_pc;
  logic        icache_ready;
  logic [31:0] icache_inst;
  logic        fet_mem_req;
  logic [31:0] fet_mem_addr;
  logic        mem_busy, mem_inst_ready;
  logic [31:0] mem_inst_addr;
  logic        fet_inst_valid;
  logic [31:0] fet_inst, fet_inst_pc;
  logic        fet_is_c, fet_pred_jump;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        is_c;
    logic        pred;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] imem [0:1023];
  logic        hit  [0:1023];

`ifdef FETCHER_PREDICT_EN
  localparam logic PRED_ON = 1'b1;
`else
  localparam logic PRED_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  assign icache_inst  = imem[fet_pc[10:1]];
  assign icache_ready = hit[fet_pc[10:1]];

  fetcher #(.RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .flush             (flush),
    .stall             (stall),
    .rob_new_pc        (rob_new_pc),
    .fet_icache_enable (fet_icache_enable),
    .fet_pc            (fet_pc),
    .icache_ready      (icache_ready),
    .icache_inst       (icache_inst),
    .fet_mem_req       (fet_mem_req),
    .fet_mem_addr      (fet_mem_addr),
    .mem_busy          (mem_busy),
    .mem_inst_ready    (mem_inst_ready),
    .mem_inst_addr     (mem_inst_addr),
    .dec_full          (dec_full),
    .fet_inst_valid    (fet_inst_valid),
    .fet_inst          (fet_inst),
    .fet_inst_pc       (fet_inst_pc),
    .fet_is_c          (fet_is_c),
    .fet_pred_jump     (fet_pred_jump)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every issue pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && fet_inst_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_issue: got pc %h inst %h expected no issue", fet_inst_pc,
                 fet_inst);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (fet_inst !== e.inst || fet_inst_pc !== e.pc || fet_is_c !== e.is_c ||
            fet_pred_jump !== e.pred) begin
          failures++;
          $display("FAIL issue: got inst %h pc %h c %b pj %b expected inst %h pc %h c %b pj %b",
                   fet_inst, fet_inst_pc, fet_is_c, fet_pred_jump, e.inst, e.pc, e.is_c,
                   e.pred);
        end
      end
    end
  end

  task automatic expect_issue(input logic [31:0] inst, input logic [31:0] pc,
                              input logic c, input logic pj);
    exp_t e;
    e.inst = inst; e.pc = pc; e.is_c = c; e.pred = pj;
    sb.push_back(e);
  endtask

  task automatic release_cycles(input int n);
    @(negedge clk) dec_full = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk) dec_full = 1'b1;
  endtask

  task automatic do_flush(input logic [31:0] target);
    @(negedge clk) begin flush = 1'b1; rob_new_pc = target; end
    @(negedge clk) flush = 1'b0;
  endtask

  task automatic mem_done(input logic [31:0] addr);
    @(negedge clk) begin mem_inst_ready = 1'b1; mem_inst_addr = addr; end
    @(negedge clk) mem_inst_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      imem[i] = 32'h0000_0013;
      hit[i]  = 1'b0;
    end
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; stall = 1'b0; dec_full = 1'b1;
    rob_new_pc = 32'h0; mem_busy = 1'b0; mem_inst_ready = 1'b0; mem_inst_addr = 32'h0;
    #1;
    check("reset_pc", fet_pc, 32'h0);
    check("reset_valid", {31'h0, fet_inst_valid}, 32'h0);
    check("reset_req", {31'h0, fet_mem_req}, 32'h0);
    check("reset_addr", fet_mem_addr, 32'h0);
    check("reset_inst", fet_inst, 32'h0);
    check("reset_pj", {31'h0, fet_pred_jump}, 32'h0);
    @(negedge clk) rst = 1'b0;

    // Sequential hits: full then compressed instruction.
    imem[0] = 32'h0000_0013; hit[0] = 1'b1;
    imem[2] = 32'h0000_0001; hit[2] = 1'b1;
    expect_issue(32'h0000_0013, 32'h0, 1'b0, 1'b0);
    expect_issue(32'h0000_0001, 32'h4, 1'b1, 1'b0);
    release_cycles(2);
    check("seq_next_pc", fet_pc, 32'h6);

    // Miss, held through mem_busy, then refill and hit.
    do_flush(32'h100);
    check("flush_pc", fet_pc, 32'h100);
    release_cycles(1);
    check("miss_req", {31'h0, fet_mem_req}, 32'h1);
    check("miss_addr", fet_mem_addr, 32'h100);
    mem_busy = 1'b1;
    repeat (3) @(negedge clk);
    check("miss_req_busy", {31'h0, fet_mem_req}, 32'h1);
    mem_busy = 1'b0;
    imem[32'h80] = 32'h0050_0093; hit[32'h80] = 1'b1;
    mem_done(32'h100);
    check("refill_req_drop", {31'h0, fet_mem_req}, 32'h0);
    expect_issue(32'h0050_0093, 32'h100, 1'b0, 1'b0);
    release_cycles(1);
    check("refill_next_pc", fet_pc, 32'h104);

    // Flush during miss; stale completion for 0x100 is ignored.
    hit[32'h80] = 1'b0;
    do_flush(32'h100);
    release_cycles(1);
    check("miss2_req", {31'h0, fet_mem_req}, 32'h1);
    do_flush(32'h200);
    check("flush_miss_req", {31'h0, fet_mem_req}, 32'h0);
    check("flush_miss_pc", fet_pc, 32'h200);
    mem_done(32'h100);
    check("stale_req", {31'h0, fet_mem_req}, 32'h0);
    check("stale_pc", fet_pc, 32'h200);
    for (int a = 32'h200; a <= 32'h210; a += 4) begin
      imem[a >> 1] = 32'h0000_0013 | (a << 20);
      hit[a >> 1]  = 1'b1;
    end
    expect_issue(32'h2000_0013, 32'h200, 1'b0, 1'b0);
    release_cycles(1);

    // Backpressure for 3 cycles between hits: no skip, no duplicate.
    expect_issue(32'h2040_0013, 32'h204, 1'b0, 1'b0);
    expect_issue(32'h2080_0013, 32'h208, 1'b0, 1'b0);
    release_cycles(2);
    repeat (3) begin
      @(negedge clk);
      check("dec_full_pc_hold", fet_pc, 32'h20C);
      check("dec_full_no_enable", {31'h0, fet_icache_enable}, 32'h0);
    end
    expect_issue(32'h20C0_0013, 32'h20C, 1'b0, 1'b0);
    expect_issue(32'h2100_0013, 32'h210, 1'b0, 1'b0);
    release_cycles(2);
    check("resume_pc", fet_pc, 32'h214);

    // rdy low freezes everything even with lookups available.
    hit[32'h214 >> 1] = 1'b1;
    @(negedge clk) begin rdy = 1'b0; dec_full = 1'b0; end
    repeat (2) @(negedge clk);
    check("rdy_low_pc", fet_pc, 32'h214);
    dec_full = 1'b1; rdy = 1'b1;

    // Completion during stall is dropped; a later one completes.
    do_flush(32'h100);
    release_cycles(1);
    @(negedge clk) begin stall = 1'b1; mem_inst_ready = 1'b1; mem_inst_addr = 32'h100; end
    @(negedge clk) begin stall = 1'b0; mem_inst_ready = 1'b0; end
    check("stall_req_held", {31'h0, fet_mem_req}, 32'h1);
    mem_done(32'h100);
    check("post_stall_req", {31'h0, fet_mem_req}, 32'h0);
    hit[32'h80] = 1'b1;
    expect_issue(32'h0050_0093, 32'h100, 1'b0, 1'b0);
    release_cycles(1);

    // JAL +0x40 at 0x10.
    imem[8] = 32'h0400_006F; hit[8] = 1'b1;
    do_flush(32'h10);
    expect_issue(32'h0400_006F, 32'h10, 1'b0, PRED_ON);
    release_cycles(1);
    check("jal_next_pc", fet_pc, PRED_ON ? 32'h50 : 32'h14);

    // Asynchronous reset mid-miss.
    hit[32'h80] = 1'b0;
    do_flush(32'h100);
    release_cycles(1);
    check("miss3_req", {31'h0, fet_mem_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", {31'h0, fet_mem_req}, 32'h0);
    check("async_rst_pc", fet_pc, 32'h0);
    check("async_rst_addr", fet_mem_addr, 32'h0);
    @(negedge clk) rst = 1'b0;
    mem_done(32'h100);
    check("post_rst_req", {31'h0, fet_mem_req}, 32'h0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
